// File: rtl/vga_frame_read_master_if.sv
// Frame-read bus bundle: Avalon-MM read master toward frame memory
// plus the Avalon-ST pixel stream leaving the block.
interface vga_frame_read_master_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_address;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W/8-1:0] m_byteenable;
    logic [DATA_W-1:0]   m_readdata;

    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;
    logic                st_sop;
    logic                st_eop;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write,
        output m_byteenable,
        input  m_readdata,
        output st_data,
        output st_valid,
        input  st_ready,
        output st_sop,
        output st_eop
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write,
        input  m_byteenable,
        output m_readdata,
        input  st_data,
        input  st_valid,
        output st_ready,
        input  st_sop,
        input  st_eop
    );
endinterface

// File: rtl/vga_frame_read_master.sv
// Frame fetch engine: sequential Avalon-MM reads into a show-ahead
// FIFO, streamed out with sop/eop framing toward the VGA pixel path.
module vga_frame_read_master #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 4800,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic go,
    input  logic abort,
    output logic busy,
    output logic done,
    vga_frame_read_master_if.master bus
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  delivered_q, delivered_d;
    logic              inflight_q, inflight_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [OCC_W-1:0]  count_q, count_d;

    logic              load;
    logic              issue;
    logic              last_issue;
    logic              frame_done;
    logic              push;
    logic              pop;
    logic              valid;
    logic [OCC_W:0]    occ_w;

    // FIFO room is judged against words stored plus the one in flight
    assign occ_w      = {1'b0, count_q} + (OCC_W + 1)'(inflight_q);
    assign issue      = (state_q == S_FETCH)
                      && (occ_w < (OCC_W + 1)'(FIFO_DEPTH));
    assign last_issue = issue
                      && (issued_q == CNT_W'(FRAME_WORDS - 1));
    assign frame_done = (state_q == S_DRAIN)
                      && (delivered_q == CNT_W'(FRAME_WORDS))
                      && !abort;

    // read data lands one cycle after its command; abort kills it
    assign push  = inflight_q;
    assign valid = (count_q != '0);
    assign pop   = valid && bus.st_ready;

    assign bus.m_address    = addr_q;
    assign bus.m_chipselect = issue;
    assign bus.m_write      = 1'b0;
    assign bus.m_byteenable = '1;

    assign bus.st_valid = valid;
    assign bus.st_data  = valid ? mem_q[rptr_q] : '0;
    assign bus.st_sop   = valid && (delivered_q == '0);
    assign bus.st_eop   = valid
                        && (delivered_q == CNT_W'(FRAME_WORDS - 1));

    // frame sequencing: idle -> fetch -> drain -> idle, abort wins
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_d = S_FETCH;
                        load    = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (last_issue) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (frame_done) begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy = (state_q != S_IDLE) && !frame_done;
    end

    // address, frame counters and FIFO bookkeeping for the next cycle
    always_comb begin
        addr_d      = addr_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        inflight_d  = issue;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        if (abort) begin
            addr_d      = ADDR_W'(BASE_ADDR);
            issued_d    = '0;
            delivered_d = '0;
            inflight_d  = 1'b0;
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
        end else if (load) begin
            addr_d      = ADDR_W'(BASE_ADDR);
            issued_d    = '0;
            delivered_d = '0;
        end else begin
            if (issue) begin
                addr_d   = addr_q + ADDR_W'(1);
                issued_d = issued_q + CNT_W'(1);
            end
            if (pop) begin
                delivered_d = delivered_q + CNT_W'(1);
                rptr_d      = rptr_q + PTR_W'(1);
            end
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // state and control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage written from the returning read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !abort) begin
            mem_q[wptr_q] <= bus.m_readdata;
        end
    end

endmodule

// File: tb/tb_vga_frame_read_master.sv
// Directed bench for the frame read master: 16-word, 1-word and
// full 4800-word frames against a latency-1 address-as-data memory.
module tb_vga_frame_read_master;

    logic clk;
    logic reset_n;

    logic go16, ab16, busy16, done16;
    logic go1, ab1, busy1, done1;
    logic gok, abk, busyk, donek;

    int n_vec;
    int n_err;

    vga_frame_read_master_if #(.ADDR_W(13), .DATA_W(32)) b16 ();
    vga_frame_read_master_if #(.ADDR_W(13), .DATA_W(32)) b1 ();
    vga_frame_read_master_if #(.ADDR_W(13), .DATA_W(32)) bk ();

    vga_frame_read_master #(.FRAME_WORDS(16)) u16 (
        .clk(clk), .reset_n(reset_n), .go(go16), .abort(ab16),
        .busy(busy16), .done(done16), .bus(b16.master)
    );

    vga_frame_read_master #(.FRAME_WORDS(1)) u1 (
        .clk(clk), .reset_n(reset_n), .go(go1), .abort(ab1),
        .busy(busy1), .done(done1), .bus(b1.master)
    );

    vga_frame_read_master #(.FRAME_WORDS(4800)) uk (
        .clk(clk), .reset_n(reset_n), .go(gok), .abort(abk),
        .busy(busyk), .done(donek), .bus(bk.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory holds its own word address as data, latency 1
    always @(posedge clk) begin
        b16.m_readdata <= 32'(b16.m_address);
        b1.m_readdata  <= 32'(b1.m_address);
        bk.m_readdata  <= 32'(bk.m_address);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int nrd, nd, exp_w, ord_err, nsop, neop, bad_sop, bad_eop;
    bit seen_done;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        go16 = 0; ab16 = 0; go1 = 0; ab1 = 0; gok = 0; abk = 0;
        b16.st_ready = 1'b1;
        b1.st_ready  = 1'b1;
        bk.st_ready  = 1'b1;

        @(negedge clk);
        chk("rst_cs", b16.m_chipselect, 0);
        chk("rst_valid", b16.st_valid, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_addr", b16.m_address, 0);
        chk("rst_be", b16.m_byteenable, 4'hf);
        chk("rst_wr", b16.m_write, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // basic 16-word frame, ready held high
        go16 = 1;
        step();
        go16 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("b_cs", b16.m_chipselect, 32'(c >= 1 && c <= 16));
            if (c <= 16) chk("b_addr", b16.m_address, c - 1);
            chk("b_valid", b16.st_valid, 32'(c >= 3 && c <= 18));
            if (c >= 3 && c <= 18) begin
                chk("b_data", b16.st_data, c - 3);
                chk("b_sop", b16.st_sop, 32'(c == 3));
                chk("b_eop", b16.st_eop, 32'(c == 18));
            end
            chk("b_busy", busy16, 32'(c <= 18));
            chk("b_done", done16, 32'(c == 19));
            step();
        end
        repeat (3) step();

        // backpressure: ready low through cycle 30
        b16.st_ready = 1'b0;
        go16 = 1;
        step();
        go16 = 0;
        nrd = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (b16.m_chipselect) nrd++;
            if (c >= 3) begin
                chk("bp_valid", b16.st_valid, 1);
                chk("bp_hold", b16.st_data, 0);
                chk("bp_sop", b16.st_sop, 1);
            end
            step();
        end
        chk("bp_reads", nrd, 8);
        b16.st_ready = 1'b1;
        exp_w = 0;
        nd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b16.m_chipselect) nrd++;
            if (b16.st_valid && b16.st_ready) begin
                chk("bp_data", b16.st_data, exp_w);
                chk("bp_sop2", b16.st_sop, 32'(exp_w == 0));
                chk("bp_eop", b16.st_eop, 32'(exp_w == 15));
                exp_w++;
            end
            if (done16) nd++;
            step();
        end
        chk("bp_words", exp_w, 16);
        chk("bp_rdtot", nrd, 16);
        chk("bp_done", nd, 1);

        // abort while the fifth word is on the stream
        go16 = 1;
        step();
        go16 = 0;
        for (int c = 1; c <= 9; c++) begin
            ab16 = (c == 7);
            @(negedge clk);
            if (c == 7) begin
                chk("ab_d4", b16.st_data, 4);
                chk("ab_v4", b16.st_valid, 1);
            end
            if (c >= 8) begin
                chk("ab_valid", b16.st_valid, 0);
                chk("ab_busy", busy16, 0);
                chk("ab_done", done16, 0);
                chk("ab_cs", b16.m_chipselect, 0);
            end
            step();
        end
        ab16 = 0;

        // restart, with go while busy and go coincident with done
        go16 = 1;
        step();
        nrd = 0;
        nd = 0;
        for (int c = 1; c <= 25; c++) begin
            go16 = (c == 5 || c == 19);
            @(negedge clk);
            if (b16.m_chipselect) nrd++;
            if (done16) nd++;
            if (c == 1) begin
                chk("rs_cs", b16.m_chipselect, 1);
                chk("rs_addr", b16.m_address, 0);
            end
            if (c == 3) begin
                chk("rs_d0", b16.st_data, 0);
                chk("rs_sop", b16.st_sop, 1);
            end
            if (c == 19) chk("rs_done", done16, 1);
            if (c > 19) chk("rs_idle", busy16, 0);
            step();
        end
        go16 = 0;
        chk("rs_reads", nrd, 16);
        chk("rs_ndone", nd, 1);

        // single-word frame
        go1 = 1;
        step();
        go1 = 0;
        nrd = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (b1.m_chipselect) nrd++;
            if (c == 1) chk("w1_addr", b1.m_address, 0);
            if (c == 3) begin
                chk("w1_valid", b1.st_valid, 1);
                chk("w1_sop", b1.st_sop, 1);
                chk("w1_eop", b1.st_eop, 1);
                chk("w1_data", b1.st_data, 0);
            end
            chk("w1_done", done1, 32'(c == 4));
            step();
        end
        chk("w1_reads", nrd, 1);

        // full frame with random ready
        gok = 1;
        step();
        gok = 0;
        exp_w = 0; ord_err = 0; nsop = 0; neop = 0;
        bad_sop = 0; bad_eop = 0; nd = 0; seen_done = 0;
        for (int c = 0; c < 20000 && !seen_done; c++) begin
            bk.st_ready = 1'($urandom % 2);
            @(negedge clk);
            if (bk.st_valid && bk.st_ready) begin
                if (bk.st_data !== 32'(exp_w)) ord_err++;
                if (bk.st_sop) begin
                    nsop++;
                    if (exp_w != 0) bad_sop++;
                end
                if (bk.st_eop) begin
                    neop++;
                    if (exp_w != 4799) bad_eop++;
                end
                exp_w++;
            end
            if (donek) begin
                nd++;
                seen_done = 1;
            end
            step();
        end
        bk.st_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (donek) nd++;
            step();
        end
        chk("rnd_words", exp_w, 4800);
        chk("rnd_order", ord_err, 0);
        chk("rnd_sop", nsop, 1);
        chk("rnd_eop", neop, 1);
        chk("rnd_sop_pos", bad_sop, 0);
        chk("rnd_eop_pos", bad_eop, 0);
        chk("rnd_done", nd, 1);

        // asynchronous reset in the middle of a fetch
        go16 = 1;
        step();
        go16 = 0;
        repeat (4) step();
        reset_n = 1'b0;
        #1;
        chk("ar_cs", b16.m_chipselect, 0);
        chk("ar_addr", b16.m_address, 0);
        chk("ar_valid", b16.st_valid, 0);
        chk("ar_data", b16.st_data, 0);
        chk("ar_sop", b16.st_sop, 0);
        chk("ar_busy", busy16, 0);
        chk("ar_done", done16, 0);
        chk("ar_be", b16.m_byteenable, 4'hf);
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("ar_ics", b16.m_chipselect, 0);
            chk("ar_ibusy", busy16, 0);
            chk("ar_ivalid", b16.st_valid, 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_frame_read_master.md
Name: vga_frame_read_master

Overview:
- Avalon-MM read master that fetches one frame of 32-bit words from the on-chip frame memory's slave port.
- Words are read sequentially from BASE_ADDR, buffered in a small show-ahead FIFO, and delivered as an Avalon-ST stream with per-frame start/end markers to the VGA pixel path.
- Started by a one-cycle go pulse from the control logic; reports busy and a done pulse.

Parameters:
- ADDR_W, 13, word address width toward the memory.
- DATA_W, 32, data width of the memory and the stream.
- BASE_ADDR, 0, first word address of the frame.
- FRAME_WORDS, 4800, words per frame (1..2^ADDR_W−BASE_ADDR).
- FIFO_DEPTH, 8, stream buffer depth (power of 2, ≥2).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  reset.
- go  in  1  start pulse; sampled only in IDLE.
- abort  in  1  synchronous abort; flushes and returns to IDLE.
- busy  out  1  high from the cycle after an accepted go until the cycle done pulses (or abort).
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- m_address  out  ADDR_W  word address.
- m_chipselect  out  1  read command strobe.
- m_write  out  1  tied 0.
- m_byteenable  out  DATA_W/8  tied all-ones.
- m_readdata  in  DATA_W  memory data, valid exactly 1 cycle after the command cycle.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream valid.
- st_ready  in  1  stream ready.
- st_sop  out  1  high with the first word of a frame.
- st_eop  out  1  high with the last word of a frame.

Behaviour:
- Clocking and reset: one clock (clk); reset_n is asynchronous, active-low. While reset_n is low, all registers clear, the FSM is in IDLE, and every output is 0 except m_byteenable (all ones) and m_write (0).
- Slave model: no waitrequest; fixed read latency 1. Every cycle with m_chipselect=1 is one accepted read. m_readdata is captured into the FIFO on the following cycle.
- FSM states and transitions:
  - IDLE: go=1 → FETCH; load addr=BASE_ADDR, issued=0, delivered=0.
  - FETCH: issue reads; when the read with issued==FRAME_WORDS−1 is issued → DRAIN.
  - DRAIN: no reads; when delivered==FRAME_WORDS → IDLE with done=1 for one cycle.
- Issue rule: m_chipselect=1 in FETCH only when fifo_count + inflight < FIFO_DEPTH. inflight is 1 if a read was issued in the previous cycle. The FIFO never overflows.
- Address: m_address = current addr; increments by 1 per issued read. No wrap inside a frame.
- Counters:
  - issued and delivered are ceil(log2(FRAME_WORDS+1)) bits wide.
  - delivered increments on st_valid & st_ready.
- Stream:
  - st_valid = FIFO non-empty.
  - st_data, st_sop and st_eop hold stable while st_valid & !st_ready.
  - st_sop = (delivered==0) & st_valid; st_eop = (delivered==FRAME_WORDS−1) & st_valid.
  - With FRAME_WORDS=1, sop and eop are asserted together.
- FIFO: show-ahead; a push and a pop in the same cycle are both honoured and the count is unchanged. A write lands in cycle n; st_valid rises in cycle n+1.
- Latency: go in cycle 0 → m_chipselect in cycle 1 → FIFO write in cycle 2 → st_valid in cycle 3.
- Throughput: one word per cycle with st_ready held at 1.
- go while busy: ignored. go in the same cycle as done: ignored; it is accepted only from IDLE on a later cycle.
- abort (any state, priority over go):
  - Next cycle: IDLE, FIFO flushed, st_valid=0, busy=0, no done.
  - Data returning in the cycle after abort is discarded.
- Backpressure: st_ready=0 indefinitely stalls issue once the FIFO fills. No data is lost or duplicated.

Test Plan:
- Basic frame (FRAME_WORDS=16, memory holds addr as data, st_ready=1): go in cycle 0 → m_address 0..15 in cycles 1..16; st_data 0..15 in cycles 3..18; sop at 0, eop at 15; done in cycle 19; busy 1 from cycle 1 through cycle 18.
- Backpressure (st_ready=0 for cycles 3..30, then 1): exactly 8 reads issued before the stall; the FIFO never exceeds 8; data sequence 0..15 intact; st_data stable while stalled.
- Random st_ready (50%, FRAME_WORDS=4800): all 4800 words delivered in order; exactly one sop and one eop; one done pulse.
- Abort at the 5th delivered word: next cycle st_valid=0, busy=0, no done. A subsequent go restarts from BASE_ADDR with sop on data 0.
- go asserted while busy, and go coincident with done: no restart and no extra reads. FRAME_WORDS=1 case: a single word with sop=eop=1.
- reset_n asserted low mid-FETCH: all outputs go to 0 immediately (asynchronously). After release, the block stays idle until go.
